pipeline_result_collector: RTL and testbench
============================================

# pipeline_result_collector

Output-side buffer placed directly downstream of the full-permutation pipeline. It captures every result pulse (`resultValid` with `pcoeffSum`, `pcoeffCount`, `eccStatus`) into a FIFO and re-emits the results as 64-bit words on a valid/ready stream toward the host DMA. The pipeline cannot stall once a result is in flight, so this block drives the pipeline's `slowDown` early enough to absorb that in-flight latency. It also keeps a result counter and sticky error flags.

## Interface
Parameters:
- DEPTH_LOG2, 6: FIFO depth is 2^DEPTH_LOG2 entries.
- SLOWDOWN_MARGIN, 16: free entries reserved for results already in flight; must be less than 2^DEPTH_LOG2.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- resultValid  in  1  one-cycle pulse from the pipeline: capture this cycle's data.
- pcoeffSum  in  48  result sum.
- pcoeffCount  in  13  result count.
- eccStatus  in  1  ECC error flag attached to this result.
- slowDown  out  1  registered; tells the pipeline to stop producing results.
- outValid  out  1  outData holds the FIFO head.
- outReady  in  1  consumer accepts the head.
- outData  out  64  {eccStatus, 2'b00, pcoeffCount[12:0], pcoeffSum[47:0]}.
- occupancy  out  DEPTH_LOG2+1  number of entries currently stored.
- resultsReceived  out  32  count of accepted results; wraps modulo 2^32.
- eccErrorSeen  out  1  sticky: some accepted result had eccStatus=1.
- overflowSeen  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- Storage: register or MLAB array with write pointer `wp`, read pointer `rp` (DEPTH_LOG2 bits each, natural wrap) and a separate occupancy counter.
- Push:
  - Condition: `resultValid && (occupancy < DEPTH || pop)`.
  - Writes the packed word at `wp`, then increments `wp`.
- Pop:
  - Condition: `outValid && outReady`.
  - Increments `rp`.
- Occupancy update: +1 on push only, -1 on pop only, unchanged when both occur or neither.
- Full FIFO, `resultValid` high and no pop:
  - The word is dropped; `wp` and occupancy are unchanged.
  - `overflowSeen` is set and `resultsReceived` does not increment.
- Full FIFO with a simultaneous pop: the push is accepted and occupancy stays at DEPTH.
- Empty FIFO with `outReady` high: no pop; the pointers do not move.
- `resultsReceived` increments on every accepted push.
- `eccErrorSeen` is set when an accepted push has eccStatus=1.
- Both sticky flags clear only on rst.
- slowDown, registered each cycle:
  - `slowDown <= rst | (occupancy_next >= 2^DEPTH_LOG2 - SLOWDOWN_MARGIN)`.
  - occupancy_next is the value after this cycle's push and pop.
- Output path:
  - outData is registered from the head entry.
  - outData holds steady while `outValid && !outReady`.
  - outData is never a read-during-write value.
- Reset values: slowDown=1 while rst is high; outValid=0; occupancy=0; resultsReceived=0; both sticky flags 0. outData is don't-care, and the implementation drives 0.
- Reset mid-operation: all stored entries are discarded. A resultValid arriving in the same cycle as rst is ignored.

## Timing
- Push-to-output latency: a push in cycle N into an empty FIFO gives outValid=1 and that word on outData in cycle N+1.
- Back-to-back pops: one word per cycle when outReady stays high and data is available. The head advances the cycle after each pop.
- slowDown latency: asserts in the cycle after occupancy reaches the threshold, and deasserts the cycle after it falls below.
- After rst drops, slowDown is 0 from the next cycle when the FIFO is empty.
- The pipeline's slowDown-to-last-result latency is at most 12 cycles. The default margin of 16 guarantees no overflow in correct operation.
- Order: strict FIFO order. Every accepted result is emitted exactly once.

## Test plan
- Reset then single push:
  - Stimulus: rst for 2 cycles, then one pulse with sum=48'h0000_1234_5678, count=13'd120, ecc=0.
  - Response: slowDown=1 during rst and 0 after. outValid=1 one cycle after the push, with outData=64'h0078_0000_1234_5678 (count=13'd120 at bits 60:48). resultsReceived=1.
- Throughput and order:
  - Stimulus: 40 consecutive pushes (sum=i, count=i) with outReady held high.
  - Response: 40 words emitted in order i=0..39. occupancy never exceeds 1. slowDown stays 0.
- Threshold:
  - Stimulus: outReady=0, 48 pushes (DEPTH=64, MARGIN=16).
  - Response: slowDown rises the cycle after the 48th push. After occupancy is drained to 47 by popping, slowDown falls one cycle later.
- Overflow:
  - Stimulus: outReady=0, 66 pushes.
  - Response: occupancy=64, overflowSeen=1, resultsReceived=64. The drained data equals the first 64 words.
- Full with simultaneous pop and push:
  - Stimulus: at occupancy 64, push and pop in the same cycle.
  - Response: occupancy stays 64, overflowSeen stays 0, and the new word is emitted last.
- ECC and reset mid-stream:
  - Stimulus: push with ecc=1, then 5 pushes, then rst for 1 cycle during continued pushes.
  - Response: eccErrorSeen=1 and outData[63]=1 for that word. After rst, eccErrorSeen=0, occupancy=0, outValid=0, and the push coincident with rst is not stored.

Source files
------------

// File: rtl/pipeline_result_collector_if.sv
// Result and output-stream signals between the permutation pipeline,
// the result collector and the host DMA consumer.
interface pipeline_result_collector_if;
  logic        resultValid;
  logic [47:0] pcoeffSum;
  logic [12:0] pcoeffCount;
  logic        eccStatus;
  logic        slowDown;
  logic        outValid;
  logic        outReady;
  logic [63:0] outData;

  // Environment side: pipeline producing results, DMA consuming words
  modport master (
    output resultValid, pcoeffSum, pcoeffCount, eccStatus, outReady,
    input  slowDown, outValid, outData
  );

  // Collector side
  modport slave (
    input  resultValid, pcoeffSum, pcoeffCount, eccStatus, outReady,
    output slowDown, outValid, outData
  );
endinterface

// File: rtl/pipeline_result_collector.sv
// Buffers pipeline results in a FIFO and re-emits them as 64-bit words on a
// valid/ready stream. Throttles the pipeline with slowDown early enough that
// results already in flight still fit, and tracks a result count plus
// sticky ECC / overflow flags.
module pipeline_result_collector #(
  parameter int DEPTH_LOG2      = 6,
  parameter int SLOWDOWN_MARGIN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_result_collector_if.slave bus,
  output logic [DEPTH_LOG2:0]     occupancy,
  output logic [31:0]             resultsReceived,
  output logic                    eccErrorSeen,
  output logic                    overflowSeen
);
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THRESH  = (DEPTH_LOG2+1)'(DEPTH - SLOWDOWN_MARGIN);

  logic [63:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;
  logic                  out_valid_q;
  logic [63:0]           out_data_q, out_data_d;
  logic                  slow_q;
  logic [31:0]           cnt_q;
  logic                  ecc_q, ovf_q;
  logic [63:0]           wdata;
  logic                  push, pop;

  // Push/pop decisions, next pointers/occupancy and the next head word
  always_comb begin
    wdata = {bus.eccStatus, 2'b00, bus.pcoeffCount, bus.pcoeffSum};
    pop   = out_valid_q && bus.outReady;
    push  = bus.resultValid && ((occ_q < DEPTH_C) || pop);
    rp_d  = rp_q + {{(DEPTH_LOG2-1){1'b0}}, pop};
    wp_d  = wp_q + {{(DEPTH_LOG2-1){1'b0}}, push};
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (!push && pop) occ_d = occ_q - 1'b1;
    // The new head is taken straight from the incoming word when it lands in
    // the slot being written this cycle, so the array is never read while
    // that same entry is being written.
    out_data_d = '0;
    if (occ_d != '0) begin
      if (push && (rp_d == wp_q)) out_data_d = wdata;
      else                        out_data_d = mem[rp_d];
    end
  end

  // Storage array; contents are meaningless until pointed to, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wdata;
  end

  // Pointers, occupancy, output register, throttle, counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      slow_q      <= 1'b1;
      cnt_q       <= '0;
      ecc_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      occ_q       <= occ_d;
      out_valid_q <= (occ_d != '0);
      out_data_q  <= out_data_d;
      slow_q      <= (occ_d >= THRESH);
      if (push) cnt_q <= cnt_q + 32'd1;
      if (push && bus.eccStatus) ecc_q <= 1'b1;
      if (bus.resultValid && !push) ovf_q <= 1'b1;
    end
  end

  assign bus.slowDown    = slow_q;
  assign bus.outValid    = out_valid_q;
  assign bus.outData     = out_data_q;
  assign occupancy       = occ_q;
  assign resultsReceived = cnt_q;
  assign eccErrorSeen    = ecc_q;
  assign overflowSeen    = ovf_q;
endmodule

// File: tb/tb_pipeline_result_collector.sv
// Bench for pipeline_result_collector: directed scenarios followed by random
// traffic, checked by a queue-based reference model and scoreboard.
module tb_pipeline_result_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  occupancy;
  logic [31:0] resultsReceived;
  logic        eccErrorSeen, overflowSeen;

  pipeline_result_collector_if bus();

  pipeline_result_collector #(.DEPTH_LOG2(6), .SLOWDOWN_MARGIN(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .occupancy(occupancy), .resultsReceived(resultsReceived),
    .eccErrorSeen(eccErrorSeen), .overflowSeen(overflowSeen)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of expected words; a result is
  // accepted when there is room after this cycle's consumption.
  logic [63:0] exp_q[$];
  int          exp_cnt;
  bit          exp_ecc, exp_ovf, exp_slow;
  bit          started = 0;

  always @(negedge clk) begin
    bit popped;
    if (started) begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("outValid", 64'(bus.outValid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("outData", bus.outData, exp_q[0]);
      chk("slowDown", 64'(bus.slowDown), 64'(exp_slow));
      chk("resultsReceived", 64'(resultsReceived), 64'(exp_cnt));
      chk("eccErrorSeen", 64'(eccErrorSeen), 64'(exp_ecc));
      chk("overflowSeen", 64'(overflowSeen), 64'(exp_ovf));
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt  = 0;
      exp_ecc  = 0;
      exp_ovf  = 0;
      exp_slow = 1;
      started  = 1;
    end else if (started) begin
      popped = (exp_q.size() != 0) && bus.outReady;
      if (popped) void'(exp_q.pop_front());
      if (bus.resultValid) begin
        if (exp_q.size() < 64) begin
          exp_q.push_back({bus.eccStatus, 2'b00, bus.pcoeffCount, bus.pcoeffSum});
          exp_cnt++;
          if (bus.eccStatus) exp_ecc = 1;
        end else begin
          exp_ovf = 1;
        end
      end
      exp_slow = (exp_q.size() >= 48);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input bit v, input logic [47:0] s, input logic [12:0] c, input bit e);
    bus.resultValid = v;
    bus.pcoeffSum   = s;
    bus.pcoeffCount = c;
    bus.eccStatus   = e;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input bit ready);
    bus.outReady = ready;
    for (int i = 0; i < n; i++) begin
      set_res(1'b1, 48'(i), 13'(i), 1'b0);
      tick();
    end
    set_res(1'b0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    bus.outReady = 1'b1;
    repeat (70) tick();
    bus.outReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_res(1'b0, '0, '0, 1'b0);
    bus.outReady = 1'b0;

    // Reset then single push
    tick();
    @(negedge clk);
    chk("slowDown_in_rst", 64'(bus.slowDown), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("slowDown_after_rst", 64'(bus.slowDown), 64'd0);
    tick();
    set_res(1'b1, 48'h0000_1234_5678, 13'd120, 1'b0);
    tick();
    set_res(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("single_outValid", 64'(bus.outValid), 64'd1);
    chk("single_outData", bus.outData, 64'h0078_0000_1234_5678);
    chk("single_count", 64'(resultsReceived), 64'd1);
    tick();
    drain();

    // Throughput and order with outReady held high
    bus.outReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_res(1'b1, 48'(i), 13'(i), 1'b0);
      @(negedge clk);
      chk("thru_occ_le1", 64'(occupancy <= 1), 64'd1);
      tick();
    end
    set_res(1'b0, '0, '0, 1'b0);
    drain();

    // Threshold
    do_reset(1);
    push_n(47, 1'b0);
    @(negedge clk);
    chk("thresh_47_slow", 64'(bus.slowDown), 64'd0);
    tick();
    set_res(1'b1, 48'd47, 13'd47, 1'b0);
    tick();
    set_res(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("thresh_48_slow", 64'(bus.slowDown), 64'd1);
    chk("thresh_48_occ", 64'(occupancy), 64'd48);
    tick();
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    @(negedge clk);
    chk("thresh_drain_occ", 64'(occupancy), 64'd47);
    chk("thresh_drain_slow", 64'(bus.slowDown), 64'd0);
    tick();
    drain();

    // Overflow
    do_reset(1);
    push_n(66, 1'b0);
    @(negedge clk);
    chk("ovf_occ", 64'(occupancy), 64'd64);
    chk("ovf_flag", 64'(overflowSeen), 64'd1);
    chk("ovf_count", 64'(resultsReceived), 64'd64);
    tick();
    drain();

    // Full with simultaneous push and pop
    do_reset(1);
    push_n(64, 1'b0);
    bus.outReady = 1'b1;
    set_res(1'b1, 48'hABCD_EF01_2345, 13'h1ABC, 1'b0);
    tick();
    bus.outReady = 1'b0;
    set_res(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("full_pp_occ", 64'(occupancy), 64'd64);
    chk("full_pp_ovf", 64'(overflowSeen), 64'd0);
    tick();
    drain();

    // ECC and reset mid-stream
    do_reset(1);
    bus.outReady = 1'b0;
    set_res(1'b1, 48'h5555, 13'd5, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_res(1'b1, 48'(100 + i), 13'(i), 1'b0);
      tick();
    end
    @(negedge clk);
    chk("ecc_flag", 64'(eccErrorSeen), 64'd1);
    chk("ecc_bit63", 64'(bus.outData[63]), 64'd1);
    tick();
    rst = 1'b1;
    set_res(1'b1, 48'h7777, 13'd7, 1'b1);
    tick();
    rst = 1'b0;
    set_res(1'b1, 48'h8888, 13'd8, 1'b0);
    @(negedge clk);
    chk("rst_ecc", 64'(eccErrorSeen), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_outValid", 64'(bus.outValid), 64'd0);
    tick();
    set_res(1'b0, '0, '0, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_res(($urandom_range(0, 99) < 60),
              {16'($urandom), 32'($urandom)},
              13'($urandom),
              ($urandom_range(0, 19) == 0));
      bus.outReady = ($urandom_range(0, 99) < 55);
      tick();
    end
    rst = 1'b0;
    set_res(1'b0, '0, '0, 1'b0);
    drain();
    @(negedge clk);
    chk("final_empty", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
